ha_bist_ctrl: RTL and testbench

Self-test initiator for the half-adder datapath inside tt_um_HA_CD. It drives operand vectors exhaustively into the adder and samples {carry,sum} after a fixed settle time. Each response is compared against a golden model, and the block reports pass/fail, a mismatch count and the first failing vector. It sits beside the adder in the user project, drives the adder's inputs and receives its outputs, and is started from a ui_in bit.

---
 rtl/ha_bist_pkg.sv | 17 +
 rtl/ha_bist_golden.sv | 15 +
 rtl/ha_bist_ctrl.sv | 155 +++++++++++++++
 tb/tb_ha_bist_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ha_bist_pkg.sv
// Shared types and constants for the half-adder self-test controller.
// Optional build macro used by the controller: HA_BIST_INJECT_EN.
package ha_bist_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_e;

   localparam int FAIL_CNT_W   = 8;
   localparam int FAIL_CNT_MAX = 255;
   localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/ha_bist_golden.sv
// Golden reference adder: WIDTH-bit a + b returned as {carry, sum}.
module ha_bist_golden #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   res
);

   // Zero-extend both operands so the carry-out lands in the top bit.
   always_comb begin
      res = {1'b0, a} + {1'b0, b};
   end

endmodule

// File: rtl/ha_bist_ctrl.sv
// Exhaustive self-test initiator for the half-adder datapath.
// Walks every {b,a} operand pair, waits SETTLE_CYC cycles, compares the
// adder response against a golden sum and reports pass/fail, a saturating
// mismatch count and the first failing vector.
// Build macro HA_BIST_INJECT_EN adds inject_err, which flips the expected
// sum LSB during CHECK so the mismatch path can be exercised.
module ha_bist_ctrl
   import ha_bist_pkg::*;
#(
   parameter int WIDTH      = 1,
   parameter int SETTLE_CYC = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      dut_sum,
   input  logic                  dut_carry,
`ifdef HA_BIST_INJECT_EN
   input  logic                  inject_err,
`endif
   output logic [WIDTH-1:0]      stim_a,
   output logic [WIDTH-1:0]      stim_b,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [FAIL_CNT_W-1:0] fail_count,
   output logic [2*WIDTH-1:0]    first_fail_vec,
   output logic                  first_fail_valid
);

   localparam int VEC_W = 2 * WIDTH;
   localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD  = SETTLE_CNT_W'(SETTLE_CYC);
   localparam logic [FAIL_CNT_W-1:0]   FAIL_SAT     = FAIL_CNT_W'(FAIL_CNT_MAX);

   state_e                  state_q, state_d;
   logic [VEC_W-1:0]        vec_q, vec_d;
   logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
   logic                    done_q, done_d;
   logic                    pass_q, pass_d;
   logic [FAIL_CNT_W-1:0]   fail_q, fail_d;
   logic [VEC_W-1:0]        ffv_q, ffv_d;
   logic                    ffvalid_q, ffvalid_d;

   logic [WIDTH:0]          exp_raw;
   logic [WIDTH:0]          exp_res;
   logic                    mismatch;

   ha_bist_golden #(.WIDTH(WIDTH)) u_golden (
      .a   (vec_q[WIDTH-1:0]),
      .b   (vec_q[VEC_W-1:WIDTH]),
      .res (exp_raw)
   );

   // Expected response, optionally corrupted to prove the checker can fail.
   always_comb begin
      exp_res = exp_raw;
`ifdef HA_BIST_INJECT_EN
      exp_res[0] = exp_raw[0] ^ inject_err;
`endif
      mismatch = ({dut_carry, dut_sum} != exp_res);
   end

   // Next-state, counters and first-fail capture.
   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      cnt_d     = cnt_q;
      done_d    = done_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      ffv_d     = ffv_q;
      ffvalid_d = ffvalid_q;

      case (state_q)
         IDLE, DONE: begin
            // A restart from DONE is identical to a fresh start from IDLE.
            if (start) begin
               state_d   = APPLY;
               vec_d     = '0;
               fail_d    = '0;
               ffv_d     = '0;
               ffvalid_d = 1'b0;
               done_d    = 1'b0;
               pass_d    = 1'b0;
            end
         end
         APPLY: begin
            cnt_d   = SETTLE_LOAD;
            state_d = (SETTLE_CYC == 0) ? CHECK : SETTLE;
         end
         SETTLE: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= 1) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (mismatch) begin
               if (fail_q != FAIL_SAT) begin
                  fail_d = fail_q + 1'b1;
               end
               if (!ffvalid_q) begin
                  ffv_d     = vec_q;
                  ffvalid_d = 1'b1;
               end
            end
            // The last vector ends the run; vec never wraps mid-run.
            if (&vec_q) begin
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = (fail_d == '0);
            end else begin
               vec_d   = vec_q + 1'b1;
               state_d = APPLY;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous reset; a reset discards all results.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         vec_q     <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= '0;
         ffv_q     <= '0;
         ffvalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         ffv_q     <= ffv_d;
         ffvalid_q <= ffvalid_d;
      end
   end

   assign stim_a           = vec_q[WIDTH-1:0];
   assign stim_b           = vec_q[VEC_W-1:WIDTH];
   assign busy             = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
   assign done             = done_q;
   assign pass             = pass_q;
   assign fail_count       = fail_q;
   assign first_fail_vec   = ffv_q;
   assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_ha_bist_ctrl.sv
// Directed bench for ha_bist_ctrl with a fault-injectable adder model and a
// queue scoreboard of expected stimulus vectors.
module tb_ha_bist_ctrl;

   localparam int WIDTH      = 1;
   localparam int SETTLE_CYC = 1;
   localparam int VEC_W      = 2 * WIDTH;
   localparam int NVEC       = 1 << VEC_W;
   localparam int CPV        = 2 + SETTLE_CYC;
   localparam int RUN        = NVEC * CPV;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] dut_sum;
   logic             dut_carry;
   logic [WIDTH-1:0] stim_a, stim_b;
   logic             busy, done, pass;
   logic [7:0]       fail_count;
   logic [VEC_W-1:0] first_fail_vec;
   logic             first_fail_valid;
`ifdef HA_BIST_INJECT_EN
   logic             inject_err = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int fault_mode = 0;   // 0 good, 1 carry stuck-at-0, 2 sum inverted
   logic [VEC_W-1:0] stim_q[$];

   always #5 clk = ~clk;

   ha_bist_ctrl #(.WIDTH(WIDTH), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .dut_sum          (dut_sum),
      .dut_carry        (dut_carry),
`ifdef HA_BIST_INJECT_EN
      .inject_err       (inject_err),
`endif
      .stim_a           (stim_a),
      .stim_b           (stim_b),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .fail_count       (fail_count),
      .first_fail_vec   (first_fail_vec),
      .first_fail_valid (first_fail_valid)
   );

   function automatic logic [WIDTH:0] faulty_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input int mode);
      logic [WIDTH:0] r;
      r = {1'b0, a} + {1'b0, b};
      if (mode == 1) r[WIDTH] = 1'b0;
      if (mode == 2) r[WIDTH-1:0] = ~r[WIDTH-1:0];
      return r;
   endfunction

   logic [WIDTH:0] adder_out;
   always_comb begin
      adder_out = faulty_add(stim_a, stim_b, fault_mode);
   end
   assign dut_sum   = adder_out[WIDTH-1:0];
   assign dut_carry = adder_out[WIDTH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full run: expected stimulus pushed at start, popped at each APPLY.
   task automatic run_full(input int mode, input bit inj, input bit hold_start);
      int efail;
      logic [VEC_W-1:0] effv;
      bit effvalid;
      logic [VEC_W-1:0] v;
      logic [WIDTH:0] gold, resp;
      efail = 0; effv = '0; effvalid = 0;
      for (int i = 0; i < NVEC; i++) begin
         v    = VEC_W'(i);
         gold = {1'b0, v[WIDTH-1:0]} + {1'b0, v[VEC_W-1:WIDTH]};
         resp = faulty_add(v[WIDTH-1:0], v[VEC_W-1:WIDTH], mode);
         if (resp != (gold ^ (WIDTH+1)'(inj))) begin
            efail++;
            if (!effvalid) begin effv = v; effvalid = 1; end
         end
         stim_q.push_back(v);
      end
      fault_mode = mode;
`ifdef HA_BIST_INJECT_EN
      inject_err = inj;
`endif
      @(negedge clk);
      start = 1'b1;
      for (int k = 1; k <= RUN; k++) begin
         @(negedge clk);
         if (k == 1 && !hold_start) start = 1'b0;
         chk("busy_run", 32'(busy), 32'd1);
         if (k == RUN) chk("done_early", 32'(done), 32'd0);
         if ((k - 1) % CPV == 0) begin
            if (stim_q.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
            else chk("stim_vec", 32'({stim_b, stim_a}), 32'(stim_q.pop_front()));
         end
      end
      @(negedge clk);
      chk("done", 32'(done), 32'd1);
      chk("busy_done", 32'(busy), 32'd0);
      chk("pass", 32'(pass), 32'(efail == 0));
      chk("fail_count", 32'(fail_count), 32'(efail));
      chk("ffv_valid", 32'(first_fail_valid), 32'(effvalid));
      chk("ffv", 32'(first_fail_vec), 32'(effv));
      chk("sb_empty", 32'(stim_q.size()), 32'd0);
      $display("run mode=%0d inj=%0d fail_count=%0d pass=%0d ffv=%0h", mode, inj, fail_count, pass, first_fail_vec);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_stim", 32'({stim_b, stim_a}), 32'd0);
      chk("rst_fail", 32'(fail_count), 32'd0);
      chk("rst_ffvalid", 32'(first_fail_valid), 32'd0);
      rst = 1'b0;

      // 1: good adder
      run_full(0, 1'b0, 1'b0);
      // 2: carry stuck-at-0
      run_full(1, 1'b0, 1'b0);
      // 3: sum inverted
      run_full(2, 1'b0, 1'b0);

      // 4: reset mid-run
      fault_mode = 2;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_done", 32'(done), 32'd0);
      chk("mr_stim", 32'({stim_b, stim_a}), 32'd0);
      chk("mr_fail", 32'(fail_count), 32'd0);
      chk("mr_ffvalid", 32'(first_fail_valid), 32'd0);
      rst = 1'b0;
      run_full(0, 1'b0, 1'b0);

      // 5: start held high across the run and into DONE
      run_full(1, 1'b0, 1'b1);
      @(negedge clk);
      chk("rs_done_clr", 32'(done), 32'd0);
      chk("rs_busy", 32'(busy), 32'd1);
      chk("rs_stim", 32'({stim_b, stim_a}), 32'd0);
      chk("rs_fail_clr", 32'(fail_count), 32'd0);
      start = 1'b0;
      n = 0;
      while (!done && n < RUN + 5) begin
         @(negedge clk);
         n++;
      end
      chk("rs_done_bound", 32'(done), 32'd1);
      chk("rs_fail", 32'(fail_count), 32'd1);
      $display("restart run fail_count=%0d cycles=%0d", fail_count, n);

`ifdef HA_BIST_INJECT_EN
      // 6: injected errors against a good adder
      run_full(0, 1'b1, 1'b0);
      run_full(0, 1'b0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
